// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared encodings and helpers for the sequential multiplier
//   MUL_OP_*      : RV32M multiply op encodings carried on the op port
//   mul_state_e   : FSM state encodings used by mul_seq
//   mul_cnt_width : width of the step counter, wide enough to hold BITWIDTH itself
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_NEG  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_e;

  // One extra bit so the remaining-step count (BITWIDTH - cnt) is representable.
  function automatic int mul_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - WIDTH-bit adder built from 4-bit carry-lookahead slices
//   a, b  in  WIDTH  addends
//   cin   in  1      carry in
//   sum   out WIDTH  a + b + cin (low WIDTH bits)
//   cout  out 1      carry out
// WIDTH must be a multiple of 4.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = WIDTH / 4;

  // Group carries ripple between slices; each slice resolves its own carries in parallel.
  logic [NG:0] gc;
  assign gc[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_cla
      logic [3:0] p;
      logic [3:0] g;
      logic [4:0] c;

      assign p    = a[4*gi +: 4] ^ b[4*gi +: 4];
      assign g    = a[4*gi +: 4] & b[4*gi +: 4];
      assign c[0] = gc[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[0]);
      assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c[0]);

      assign sum[4*gi +: 4] = p ^ c[3:0];
      assign gc[gi+1]       = c[4];
    end
  endgenerate

  assign cout = gc[NG];

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
//   clk        in   1         clock
//   rst        in   1         synchronous active-high reset
//   flush      in   1         abort current op, back to IDLE next edge
//   in_valid   in   1         operands valid
//   in_ready   out  1         high only in IDLE
//   op         in   2         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   src1       in   BITWIDTH  multiplicand (rs1)
//   src2       in   BITWIDTH  multiplier (rs2)
//   out_valid  out  1         result valid, held until out_ready
//   out_ready  in   1         consumer accepts result
//   result     out  BITWIDTH  low word (MUL) or high word (MULH*)
// Optional macro MUL_EARLY_OUT_EN: finish early once the unconsumed multiplier bits are zero.
module mul_seq
  import mul_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic [BITWIDTH-1:0] src1,
  input  logic [BITWIDTH-1:0] src2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] result
);

  localparam int CW = mul_cnt_width(BITWIDTH);
  localparam int W2 = 2 * BITWIDTH;

  mul_state_e          state;
  mul_op_e             op_q;
  logic [BITWIDTH-1:0] mcand;
  logic [BITWIDTH-1:0] acc;
  logic [BITWIDTH-1:0] mplr;
  logic [CW-1:0]       cnt;
  logic                neg;

  // Operand conditioning: multiply magnitudes, fix the sign up in NEG.
  logic                sign1, sign2;
  logic [BITWIDTH-1:0] abs1, abs2;

  always_comb begin
    sign1 = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && src1[BITWIDTH-1];
    sign2 = (op == MUL_OP_MULH) && src2[BITWIDTH-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    abs1  = sign1 ? (~src1 + BITWIDTH'(1)) : src1;
    abs2  = sign2 ? (~src2 + BITWIDTH'(1)) : src2;
  end

  // One partial-product step: acc + (mplr[0] ? mcand : 0).
  logic [BITWIDTH-1:0] step_b;
  logic [BITWIDTH-1:0] step_sum;
  logic                step_cout;

  assign step_b = mplr[0] ? mcand : '0;

  adder #(.WIDTH(BITWIDTH)) u_step_add (
    .a    (acc),
    .b    (step_b),
    .cin  (1'b0),
    .sum  (step_sum),
    .cout (step_cout)
  );

  // Two's complement negate of the full product: ~P + 0 + 1.
  logic [W2-1:0] neg_sum;
  logic          unused_neg_cout;

  adder #(.WIDTH(W2)) u_neg_add (
    .a    (~{acc, mplr}),
    .b    ('0),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (unused_neg_cout)
  );

  // Next {acc, mplr} in CALC and whether this is the final CALC cycle.
  logic [W2-1:0] calc_p;
  logic          calc_last;

`ifdef MUL_EARLY_OUT_EN
  // Low (BITWIDTH - cnt) bits of mplr are still unconsumed multiplier bits; the rest
  // already hold low product bits. If no further add can be nonzero, one barrel
  // shift by the remaining count finishes the job.
  logic [BITWIDTH-1:0] rem_mask;
  logic [CW-1:0]       rem_cnt;
  logic                early_out;

  always_comb begin
    rem_mask  = {BITWIDTH{1'b1}} >> cnt;
    rem_cnt   = CW'(BITWIDTH) - cnt;
    early_out = ((mplr & rem_mask) == '0) || (mcand == '0);
    calc_p    = early_out ? ({acc, mplr} >> rem_cnt)
                          : {step_cout, step_sum, mplr[BITWIDTH-1:1]};
    calc_last = early_out || (cnt == CW'(BITWIDTH - 1));
  end
`else
  always_comb begin
    calc_p    = {step_cout, step_sum, mplr[BITWIDTH-1:1]};
    calc_last = (cnt == CW'(BITWIDTH - 1));
  end
`endif

  // Final signed product and the word writeback wants.
  logic [W2-1:0]       p_final;
  logic [BITWIDTH-1:0] result_sel;

  always_comb begin
    p_final    = neg ? neg_sum : {acc, mplr};
    result_sel = (op_q == MUL_OP_MUL) ? p_final[BITWIDTH-1:0] : p_final[W2-1:BITWIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      op_q      <= MUL_OP_MUL;
      mcand     <= '0;
      acc       <= '0;
      mplr      <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= mul_op_e'(op);
            neg      <= sign1 ^ sign2;
            mcand    <= abs1;
            acc      <= '0;
            mplr     <= abs2;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          {acc, mplr} <= calc_p;
          cnt         <= cnt + CW'(1);
          if (calc_last) state <= ST_NEG;
        end
        ST_NEG: begin
          // Always spent, even for a positive product, to keep latency fixed.
          if (neg) {acc, mplr} <= neg_sum;
          result    <= result_sel;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed self-checking bench for mul_seq
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mul_seq #(.BITWIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Called #1 after an edge with the DUT idle. lat counts edges from the accepting
  // edge (inclusive) until out_valid is seen; 100 means it never came.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit ack, output logic [31:0] res, output int lat);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got=%h exp=0", result); else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_basic;
    logic [31:0] r; int lat;
    run_op(2'b00, 32'd7, 32'd6, 1'b1, r, lat);
    checks++; if (r !== 32'h0000002A) $display("FAIL mul_7x6 got=%h exp=0000002a", r); else passes++;
`ifdef MUL_EARLY_OUT_EN
    checks++; if (lat < 3 || lat > 34) $display("FAIL mul_7x6_latency got=%0d exp=3..34", lat); else passes++;
`else
    checks++; if (lat !== 34) $display("FAIL mul_7x6_latency got=%0d exp=34", lat); else passes++;
`endif
  endtask

  task automatic test_edges;
    logic [31:0] r; int lat;
    run_op(2'b01, 32'h80000000, 32'h80000000, 1'b1, r, lat);
    checks++; if (r !== 32'h40000000) $display("FAIL mulh_min_min got=%h exp=40000000", r); else passes++;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
    checks++; if (r !== 32'h00000000) $display("FAIL mulh_m1_m1 got=%h exp=00000000", r); else passes++;
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu_ones got=%h exp=ffffffff", r); else passes++;
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
    checks++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu_ones got=%h exp=fffffffe", r); else passes++;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
    checks++; if (r !== 32'h00000001) $display("FAIL mul_ones got=%h exp=00000001", r); else passes++;
    run_op(2'b01, 32'h80000000, 32'h00000003, 1'b1, r, lat);
    checks++; if (r !== 32'hFFFFFFFE) $display("FAIL mulh_min_3 got=%h exp=fffffffe", r); else passes++;
  endtask

  task automatic test_backpressure;
    logic [31:0] r; int lat;
    run_op(2'b11, 32'h12345678, 32'h9ABCDEF0, 1'b0, r, lat);
    checks++; if (r !== 32'h0B00EA4E) $display("FAIL bp_result got=%h exp=0b00ea4e", r); else passes++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); else passes++;
      checks++; if (result !== 32'h0B00EA4E) $display("FAIL bp_result_stable cyc=%0d got=%h exp=0b00ea4e", i, result); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); else passes++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); else passes++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; int lat;
    run_op(2'b00, 32'd3, 32'd5, 1'b1, r, lat);
    checks++; if (r !== 32'd15) $display("FAIL b2b_first got=%h exp=0000000f", r); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got=%b exp=1", in_ready); else passes++;
    run_op(2'b11, 32'h80000000, 32'd4, 1'b1, r, lat);
    checks++; if (r !== 32'h00000002) $display("FAIL b2b_second got=%h exp=00000002", r); else passes++;
  endtask

  task automatic test_flush;
    logic [31:0] r; int lat; int seen;
    op = 2'b00; src1 = 32'h00001234; src2 = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b exp=1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid); else passes++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL flush_no_result got=%0d exp=0", seen); else passes++;
    run_op(2'b00, 32'd7, 32'd6, 1'b1, r, lat);
    checks++; if (r !== 32'h0000002A) $display("FAIL flush_next_op got=%h exp=0000002a", r); else passes++;
  endtask

  task automatic test_flush_beats_valid;
    int seen;
    op = 2'b00; src1 = 32'd9; src2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_vs_valid_in_ready got=%b exp=1", in_ready); else passes++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL flush_vs_valid_dropped got=%0d exp=0", seen); else passes++;
  endtask

  task automatic test_reset_midop;
    op = 2'b00; src1 = 32'd100; src2 = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (result !== 32'h0) $display("FAIL rst_mid_result got=%h exp=0", result); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); else passes++;
  endtask

  task automatic test_early_out;
    logic [31:0] r; int lat;
    run_op(2'b00, 32'h12345678, 32'd2, 1'b1, r, lat);
    checks++; if (r !== 32'h2468ACF0) $display("FAIL early_mul got=%h exp=2468acf0", r); else passes++;
`ifdef MUL_EARLY_OUT_EN
    checks++; if (lat >= 34 || lat < 3) $display("FAIL early_latency got=%0d exp=3..33", lat); else passes++;
    run_op(2'b00, 32'd0, 32'hDEADBEEF, 1'b1, r, lat);
    checks++; if (lat !== 3) $display("FAIL early_zero_latency got=%0d exp=3", lat); else passes++;
    checks++; if (r !== 32'h0) $display("FAIL early_zero got=%h exp=0", r); else passes++;
`else
    checks++; if (lat !== 34) $display("FAIL fixed_latency got=%0d exp=34", lat); else passes++;
`endif
  endtask

  task automatic test_random;
    logic [31:0] r, a, b, e; logic [1:0] o; int lat;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; o = 2'($urandom_range(0, 3));
      if (i == 0) b = 32'h00000010;
      e = ref_mul(o, a, b);
      run_op(o, a, b, 1'b1, r, lat);
      checks++; if (r !== e) $display("FAIL random_%0d op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, r, e); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_edges();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_flush_beats_valid();
    test_reset_midop();
    test_early_out();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
